// File: rtl/sha256_nonce_sched.sv
// Nonce sequencer for a looped SHA-256 core.
// Issues one nonce per LOOP cycles, tags it, and checks the returning hash.
module sha256_nonce_sched #(
  parameter int LOOP       = 4,
  parameter int NUM_ROUNDS = 64,
  parameter int RESULT_LAT = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [95:0]  job_data,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic         abort,
  output logic [5:0]   core_cnt,
  output logic         core_feedback,
  output logic [255:0] core_rx_state,
  output logic [511:0] core_rx_input,
  input  logic [255:0] core_tx_hash,
  output logic         gold_valid,
  input  logic         gold_ready,
  output logic [31:0]  gold_nonce,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [31:0]  hash_count
);

  localparam bit CFG_OK = (LOOP >= 1) && (LOOP <= 32) &&
                          (NUM_ROUNDS % LOOP == 0) &&
                          (RESULT_LAT == NUM_ROUNDS + 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("sha256_nonce_sched: inconsistent LOOP/NUM_ROUNDS/RESULT_LAT");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [5:0]    phase;
  logic [5:0]    phase_nx;
  logic [255:0]  midstate;
  logic [95:0]   data;
  logic [31:0]   nonce;
  logic [31:0]   nonce_end;
  logic          fmt_en;

  logic [RESULT_LAT-1:0] tag_v;
  logic [31:0]           tag_n [RESULT_LAT];

  logic accept;
  logic issue;
  logic any_v;
  logic retire;
  logic golden;
  logic pop;
  logic [223:0] unused_hash;

  assign unused_hash = core_tx_hash[223:0];

  assign phase_nx = (phase == 6'(LOOP - 1)) ? 6'd0 : phase + 6'd1;
  assign accept   = job_valid && (state == IDLE) && !abort;
  assign issue    = (state == RUN) && (phase == 6'd0);
  assign any_v    = |tag_v;
  assign retire   = tag_v[RESULT_LAT-1] && !abort;
  assign golden   = retire && (core_tx_hash[255:224] == 32'd0);
  assign pop      = gold_valid && gold_ready;

  assign job_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign core_cnt      = phase;
  assign core_feedback = (phase != 6'd0);
  assign core_rx_state = midstate;
  assign core_rx_input = fmt_en ?
    {32'h0000_0280, 320'd0, 32'h8000_0000, nonce, data} : 512'd0;

  // Job FSM: accept, issue nonces, drain the line, abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 6'd0;
      midstate  <= 256'd0;
      data      <= 96'd0;
      nonce     <= 32'd0;
      nonce_end <= 32'd0;
      fmt_en    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        phase <= 6'd0;
      end else begin
        unique case (state)
          IDLE: begin
            phase <= 6'd0;
            if (job_valid) begin
              midstate  <= job_midstate;
              data      <= job_data;
              nonce     <= job_nonce_start;
              nonce_end <= job_nonce_end;
              fmt_en    <= 1'b1;
              state     <= RUN;
            end
          end
          RUN: begin
            phase <= phase_nx;
            if (issue) begin
              if (nonce == nonce_end) state <= DRAIN;
              else nonce <= nonce + 32'd1;
            end
          end
          DRAIN: begin
            if (!any_v) begin
              done  <= 1'b1;
              state <= IDLE;
              phase <= 6'd0;
            end else begin
              phase <= phase_nx;
            end
          end
          default: begin
            state <= IDLE;
            phase <= 6'd0;
          end
        endcase
      end
    end
  end

  // Tag valid line: one push per cycle, wiped on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
    end else if (abort) begin
      tag_v <= '0;
    end else begin
      tag_v <= {tag_v[RESULT_LAT-2:0], issue};
    end
  end

  // Tag nonce line: payload only, meaningful where tag_v is set.
  always_ff @(posedge clk) begin
    tag_n[0] <= nonce;
    for (int i = 1; i < RESULT_LAT; i++) begin
      tag_n[i] <= tag_n[i-1];
    end
  end

  // Retire: count hashes, hold one golden nonce, flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gold_valid <= 1'b0;
      gold_nonce <= 32'd0;
      overflow   <= 1'b0;
      hash_count <= 32'd0;
    end else begin
      if (accept) overflow <= 1'b0;
      if (retire) hash_count <= hash_count + 32'd1;
      if (pop) gold_valid <= 1'b0;
      if (golden) begin
        if (!gold_valid || pop) begin
          gold_valid <= 1'b1;
          gold_nonce <= tag_n[RESULT_LAT-1];
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
